// File: rtl/psx_pad_pkg.sv
// rtl/psx_pad_pkg.sv - shared constants, state encoding and transmit byte table for the PSX pad device
package psx_pad_pkg;

    localparam logic [7:0] PSX_ADDR       = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_ID_TAIL    = 8'h5A;
    localparam int         PSX_BYTES      = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK_WAIT,
        ST_ACK_PULSE,
        ST_IGNORE,
        ST_DONE
    } state_e;

    // Buttons are active-low on the bus, hence the inversion of the pressed=1 shadow.
    function automatic logic [7:0] tx_byte_sel(input logic [2:0] idx, input logic [15:0] btn);
        case (idx)
            3'd0:    return 8'hFF;
            3'd1:    return PSX_ID_DIGITAL;
            3'd2:    return PSX_ID_TAIL;
            3'd3:    return ~btn[7:0];
            3'd4:    return ~btn[15:8];
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/psx_pad_device_sync.sv
// rtl/psx_pad_device_sync.sv - multi-stage input synchronizer with registered rise/fall strobes
module psx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        chain_d    = chain_q;
        chain_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
        prev_d = chain_q[STAGES-1];
        rise_d = chain_q[STAGES-1] & ~prev_q;
        fall_d = ~chain_q[STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sync = chain_q[STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/psx_pad_device.sv
// rtl/psx_pad_device.sv - device-side PSX digital pad emulator answering the 5-byte poll
// Optional motor byte capture enabled by defining PSX_PAD_MOTOR_CAPTURE_EN.
module psx_pad_device
    import psx_pad_pkg::*;
#(
    parameter int ACK_DELAY   = 4,
    parameter int ACK_LEN     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic        att,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack,
    output logic        busy,
    output logic        xfer_done
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
    ,
    output logic [15:0] motor
`endif
);

    logic clk_rise, clk_fall, att_rise, att_fall, cmd_s;
    logic psx_clk_level_unused, att_level_unused, cmd_rise_unused, cmd_fall_unused;

    psx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .din(psx_clk),
        .sync(psx_clk_level_unused), .rise(clk_rise), .fall(clk_fall)
    );
    psx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cmd (
        .clk(clk), .rst_n(rst_n), .din(cmd),
        .sync(cmd_s), .rise(cmd_rise_unused), .fall(cmd_fall_unused)
    );
    psx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_att (
        .clk(clk), .rst_n(rst_n), .din(att),
        .sync(att_level_unused), .rise(att_rise), .fall(att_fall)
    );

    state_e      state_q, state_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [15:0] btn_q, btn_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        data_bit_q, data_bit_d;
    logic        xfer_done_q, xfer_done_d;
    logic [7:0]  rx_next, tx_byte;
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
    logic [7:0]  rx3_q, rx3_d;
    logic [15:0] motor_q, motor_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= '0;
            bit_idx_q   <= '0;
            rx_byte_q   <= '0;
            btn_q       <= '0;
            cnt_q       <= '0;
            data_bit_q  <= 1'b1;
            xfer_done_q <= 1'b0;
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
            rx3_q       <= '0;
            motor_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            bit_idx_q   <= bit_idx_d;
            rx_byte_q   <= rx_byte_d;
            btn_q       <= btn_d;
            cnt_q       <= cnt_d;
            data_bit_q  <= data_bit_d;
            xfer_done_q <= xfer_done_d;
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
            rx3_q       <= rx3_d;
            motor_q     <= motor_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        bit_idx_d   = bit_idx_q;
        rx_byte_d   = rx_byte_q;
        btn_d       = btn_q;
        cnt_d       = cnt_q;
        data_bit_d  = data_bit_q;
        xfer_done_d = 1'b0;
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
        rx3_d       = rx3_q;
        motor_d     = motor_q;
`endif
        rx_next = {cmd_s, rx_byte_q[7:1]};
        tx_byte = tx_byte_sel(byte_idx_q, btn_q);

        unique case (state_q)
            ST_IDLE: begin
                if (att_fall) begin
                    state_d    = ST_SHIFT;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    btn_d      = buttons;
                    data_bit_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    data_bit_d = tx_byte[bit_idx_q];
                end
                if (clk_rise) begin
                    rx_byte_d = rx_next;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        if ((byte_idx_q == 3'd0 && rx_next != PSX_ADDR) ||
                            (byte_idx_q == 3'd1 && rx_next != PSX_CMD_POLL)) begin
                            state_d = ST_IGNORE;
                        end else if (byte_idx_q == 3'(PSX_BYTES - 1)) begin
                            state_d     = ST_DONE;
                            xfer_done_d = 1'b1;
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
                            motor_d     = {rx_next, rx3_q};
`endif
                        end else begin
                            state_d = ST_ACK_WAIT;
                            cnt_d   = 8'(ACK_DELAY - 1);
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
                            if (byte_idx_q == 3'd3) rx3_d = rx_next;
`endif
                        end
                    end
                end
            end
            ST_ACK_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_ACK_PULSE;
                    cnt_d   = 8'(ACK_LEN - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACK_PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d    = ST_SHIFT;
                    byte_idx_d = byte_idx_q + 3'd1;
                    bit_idx_d  = '0;
                    data_bit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_IGNORE, ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        // Deselect wins over everything: abort without completing or capturing.
        if (att_rise) begin
            state_d     = ST_IDLE;
            xfer_done_d = 1'b0;
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
            motor_d     = motor_q;
`endif
        end
    end

    always_comb begin
        data      = 1'b1;
        ack       = 1'b1;
        busy      = (state_q != ST_IDLE);
        xfer_done = xfer_done_q;
        if (state_q == ST_SHIFT)     data = data_bit_q;
        if (state_q == ST_ACK_PULSE) ack  = 1'b0;
    end

`ifdef PSX_PAD_MOTOR_CAPTURE_EN
    assign motor = motor_q;
`endif

endmodule

// File: tb/tb_psx_pad_device.sv
// tb/tb_psx_pad_device.sv - scoreboard bench driving the pad bus as a PSX host
module tb_psx_pad_device;

    localparam int HALF = 8;
    localparam int SS   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psx_clk = 1'b1;
    logic        cmd = 1'b1;
    logic        att = 1'b1;
    logic [15:0] buttons = 16'h0000;
    wire         data, ack, busy, xfer_done;
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
    wire  [15:0] motor;
`endif

    int         total = 0;
    int         bad = 0;
    int         ack_cnt = 0;
    int         xfer_cnt = 0;
    int         ack_run = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sh = 8'h00;
    int         nb = 0;

    psx_pad_device dut (
        .clk(clk), .rst_n(rst_n), .psx_clk(psx_clk), .cmd(cmd), .att(att),
        .buttons(buttons), .data(data), .ack(ack), .busy(busy), .xfer_done(xfer_done)
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
        , .motor(motor)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Host-side receiver: assemble bytes as the host samples data on psx_clk rise.
    always @(posedge psx_clk or posedge att) begin
        if (att) begin
            nb = 0;
        end else begin
            sh = {data, sh[7:1]};
            nb++;
            if (nb == 8) begin
                nb = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_byte_unexpected: got %h want none", sh);
                end else begin
                    check("rx_byte", {24'h0, sh}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ack === 1'b0) begin
            ack_run++;
        end else if (ack_run > 0) begin
            ack_cnt++;
            if (rst_n) check("ack_len", ack_run, 2);
            ack_run = 0;
        end
        if (xfer_done === 1'b1) xfer_cnt++;
    end

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            psx_clk = 1'b0;
            cmd = b[i];
            repeat (HALF) @(negedge clk);
            psx_clk = 1'b1;
            if (i != n - 1) repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic wait_ack_low();
        int k;
        k = 0;
        while (ack === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ack_seen", ack, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit want_ack);
        int k;
        send_bits(b, 8);
        if (want_ack) begin
            wait_ack_low();
            k = 0;
            while (ack === 1'b0 && k < 40) begin
                @(negedge clk);
                k++;
            end
            repeat (2) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic select_dev();
        @(negedge clk);
        att = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic deselect_dev();
        check("busy_selected", busy, 1);
        @(negedge clk);
        att = 1'b1;
        repeat (SS + 2) @(negedge clk);
        check("busy_after_att", busy, 0);
        check("data_after_att", data, 1);
        check("ack_after_att", ack, 1);
    endtask

    // host/resp packed with byte0 in bits [7:0]
    task automatic xact(input logic [39:0] host, input logic [39:0] resp, input bit addressed);
        int a0, x0;
        a0 = ack_cnt;
        x0 = xfer_cnt;
        for (int i = 0; i < 5; i++) exp_q.push_back(resp[8*i +: 8]);
        select_dev();
        for (int i = 0; i < 5; i++) send_byte(host[8*i +: 8], addressed && (i < 4));
        deselect_dev();
        check("ack_count", ack_cnt - a0, addressed ? 4 : 0);
        check("xfer_count", xfer_cnt - x0, addressed ? 1 : 0);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int a0, x0;
        #1;
        check("rst_data", data, 1);
        check("rst_ack", ack, 1);
        check("rst_busy", busy, 0);
        check("rst_xfer_done", xfer_done, 0);
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
        check("rst_motor", motor, 16'h0000);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // basic poll
        buttons = 16'h0009;
        xact(40'h00_00_00_42_01, 40'hFF_F6_5A_41_FF, 1'b1);
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
        check("motor_zero", motor, 16'h0000);
`endif

        // motor bytes and a second button pattern
        buttons = 16'h1234;
        xact(40'h3C_A5_00_42_01, 40'hED_CB_5A_41_FF, 1'b1);
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
        check("motor_capture", motor, 16'h3CA5);
`endif

        // wrong address: ignored, then normal recovery
        buttons = 16'h0000;
        xact(40'h00_00_00_42_81, 40'hFF_FF_FF_FF_FF, 1'b0);
        xact(40'h00_00_00_42_01, 40'hFF_FF_5A_41_FF, 1'b1);

        // abort after 3 bits of byte 3
        a0 = ack_cnt;
        x0 = xfer_cnt;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h5A);
        select_dev();
        send_byte(8'h01, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h00, 1'b1);
        send_bits(8'hFF, 3);
        repeat (HALF) @(negedge clk);
        deselect_dev();
        check("abort_ack_count", ack_cnt - a0, 3);
        check("abort_xfer_count", xfer_cnt - x0, 0);
`ifdef PSX_PAD_MOTOR_CAPTURE_EN
        check("abort_motor", motor, 16'h3CA5);
`endif

        // buttons change mid-transaction; shadow holds
        buttons = 16'h0000;
        fork
            xact(40'h00_00_00_42_01, 40'hFF_FF_5A_41_FF, 1'b1);
            begin
                repeat (60) @(negedge clk);
                buttons = 16'hFFFF;
            end
        join
        xact(40'h00_00_00_42_01, 40'h00_00_5A_41_FF, 1'b1);

        // async reset during the ack pulse
        exp_q.push_back(8'hFF);
        select_dev();
        send_bits(8'h01, 8);
        wait_ack_low();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_ack", ack, 1);
        check("rstmid_data", data, 1);
        check("rstmid_busy", busy, 0);
        att = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        buttons = 16'h0009;
        xact(40'h00_00_00_42_01, 40'hFF_F6_5A_41_FF, 1'b1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psx_pad_device.md
Name: psx_pad_device

Overview:
- Emulates a PSX digital controller on the device side of the pad bus. Consumes psx_clk/cmd/att from fake_psx_two and drives data/ack back to it.
- Answers the standard poll transaction (5 bytes) with ID 0x41 and the current button state.
- Used to close the loop around fake_psx_two in simulation and on the board, with no real pad attached.

Parameters:
- ACK_DELAY, 4: clk cycles from the 8th psx_clk rising edge of a byte to ack falling.
- ACK_LEN, 2: clk cycles ack is held low.
- SYNC_STAGES, 2: flop stages on each bus input.

Ports:
- clk  in  1  system clock; must be at least 8x the psx_clk rate.
- rst_n  in  1  asynchronous, active-low reset.
- psx_clk  in  1  bus clock from host; idle high.
- cmd  in  1  host-to-device serial data, LSB first.
- att  in  1  active-low select from host.
- buttons  in  16  pressed = 1; bit0 = SELECT … bit15 = SQUARE, standard order.
- data  out  1  device-to-host serial data, LSB first; idle high.
- ack  out  1  active-low acknowledge pulse.
- busy  out  1  high while a transaction is selected.
- xfer_done  out  1  one-clk pulse when byte 4 completes.

Behaviour:
- Reset values: data=1, ack=1, busy=0, xfer_done=0. State=IDLE, byte_idx=0, bit_idx=0.
- Input path: psx_clk, cmd and att each pass through SYNC_STAGES flops, then edge detect.
- Edge latency: detected edges lag the pins by SYNC_STAGES+1 clk.
- Bus timing:
  - On a detected psx_clk falling edge, data is driven with bit bit_idx of tx_byte.
  - On a detected rising edge, cmd is shifted into rx_byte[7] (shift right) and bit_idx increments.
- Transmit bytes by index: 0 → 0xFF; 1 → 0x41; 2 → 0x5A; 3 → ~buttons[7:0]; 4 → ~buttons[15:8].
- buttons are latched into a shadow register on detected att fall. Later changes are ignored until the next transaction.
- States:
  - IDLE: data=1, ack=1. Detected att fall → SHIFT, busy=1, byte_idx=0, bit_idx=0.
  - SHIFT: on the 8th rising edge, check rx_byte:
    - byte0 must equal 0x01 and byte1 must equal 0x42; a mismatch → IGNORE.
    - If byte_idx<4 → ACK_WAIT.
    - If byte_idx==4 → pulse xfer_done, go to DONE. No ack after the last byte.
  - ACK_WAIT: count ACK_DELAY clks → ACK_PULSE. data returns to 1 on entry.
  - ACK_PULSE: ack=0 for ACK_LEN clks, then ack=1, byte_idx++, bit_idx=0 → SHIFT.
  - IGNORE: data=1, ack=1, bus edges ignored until att rises.
  - DONE: data=1, wait for att rise.
- Detected att rise in any state → IDLE on the next clk:
  - data=1, ack=1, busy=0.
  - An ack pulse in progress is truncated.
  - Partial bytes are discarded; no xfer_done.
- psx_clk edges seen during ACK_WAIT/ACK_PULSE are a host protocol violation. They are dropped; the bit counter does not advance.
- att low while psx_clk is low at selection: only edges after selection count.
- Reset mid-transaction forces the reset values immediately (asynchronous reset).

Optional Feature:
- Macro: PSX_PAD_MOTOR_CAPTURE_EN.
- When defined: adds output motor[15:0] (reset 0x0000).
  - rx bytes 3 and 4 are written to motor[7:0] and motor[15:8], both on xfer_done.
  - The transaction must be complete and addressed; aborted or IGNOREd transactions leave motor unchanged.
- When undefined: no motor port; rx bytes 3 and 4 are discarded.

Decomposition:
- Package psx_pad_pkg holds:
  - constants PSX_ADDR=8'h01, PSX_CMD_POLL=8'h42, PSX_ID_DIGITAL=8'h41, PSX_ID_TAIL=8'h5A, PSX_BYTES=5;
  - state encoding for IDLE/SHIFT/ACK_WAIT/ACK_PULSE/IGNORE/DONE.
- Sub-module psx_sync: a SYNC_STAGES-deep synchronizer with registered rise/fall strobes. Instantiated three times, once each for psx_clk, cmd and att.

Test Plan:
1. Host sends 01 42 00 00 00 with buttons=16'h0009 → data bytes FF 41 5A F6 FF. Exactly 4 ack pulses, each ACK_LEN=2 clk long. One xfer_done. busy falls within SYNC_STAGES+2 clk of att rise.
2. Byte0=0x81 → data stays 1 for the whole transaction, no ack, no xfer_done. The next correct transaction responds normally.
3. att raised after 3 bits of byte 3 → data=1, ack=1, busy=0 within SYNC_STAGES+2 clk. No xfer_done; under PSX_PAD_MOTOR_CAPTURE_EN, motor unchanged.
4. buttons changes from 0x0000 to 0xFFFF mid-transaction → bytes 3/4 still read FF FF. The next transaction reads 00 00.
5. rst_n asserted during ACK_PULSE → ack=1 and data=1 immediately, without waiting for a clk edge. A transaction after release responds FF 41 5A ….
6. PSX_PAD_MOTOR_CAPTURE_EN defined, host bytes 01 42 00 A5 3C → motor=16'h3CA5 the clk after xfer_done.
